mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between two requesters: the instruction-fetch stage (IF) and the data path (D), which issues loads/stores from the decoder's MemRead/MemWrite.
- One outstanding memory transaction at a time. Data has priority, with an anti-starvation limit for fetch.
- Sits between the IF/MEM pipeline stages and the memory; the pipeline stalls on missing grant or response.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter sharing a single memory port between fetch and data, data first with fetch anti-starvation and a response timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SL = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TM = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d, bus_err_q, bus_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          idle, d_win, rd_done, done, tmo_hit, fin;
  always_comb begin
    idle     = state_q == IDLE;
    d_win    = d_req && !(if_req && starve_q == SL);
    d_gnt    = idle && d_win;
    if_gnt   = idle && if_req && !d_win;
    rd_done  = mem_rvalid && !mem_we_q && (state_q == RESP || (state_q == REQ && mem_ack));
    done     = rd_done || (state_q == REQ && mem_ack && mem_we_q);
    tmo_hit  = !idle && tmo_q == TM && !done;
    fin      = done || tmo_hit;
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_d       = idle ? tmo_q : tmo_q + 1'b1;
    mem_req_d   = (state_q == REQ && (mem_ack || tmo_hit)) ? 1'b0 : mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (d_gnt || if_gnt) begin
      state_d     = REQ;
      owner_d     = d_gnt;
      tmo_d       = '0;
      mem_req_d   = 1'b1;
      mem_we_d    = d_gnt && d_we;
      mem_addr_d  = d_gnt ? d_addr : if_addr;
      mem_wdata_d = d_gnt ? d_wdata : 32'h0;
      starve_d    = (d_gnt && if_req) ? ((starve_q == SL) ? starve_q : starve_q + 1'b1) : '0;
    end
    else if (fin)
      state_d = IDLE;
    else if (state_q == REQ && mem_ack)
      state_d = RESP;
    // rdata registers hold between completions; a failed or store completion returns 0
    if_rvalid_d = fin && !owner_q;
    d_rvalid_d  = fin && owner_q;
    bus_err_d   = tmo_hit;
    if_rdata_d  = (fin && !owner_q) ? (rd_done ? mem_rdata : 32'h0) : if_rdata_q;
    d_rdata_d   = (fin && owner_q) ? (rd_done ? mem_rdata : 32'h0) : d_rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 0, d_req = 0, d_we = 0, mem_ack = 0, mem_rvalid = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, bus_err, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  int          total = 0, passed = 0, failed = 0;
  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mem_req"}, {31'h0, mem_req}, 0);
    chk({tag, "_mem_we"}, {31'h0, mem_we}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rvalids"}, {30'h0, if_rvalid, d_rvalid}, 0);
    chk({tag, "_rdatas"}, if_rdata | d_rdata, 0);
    chk({tag, "_bus_err"}, {31'h0, bus_err}, 0);
  endtask
  initial begin
    tick(); tick();
    chk_idle_outs("reset");
    reset = 1'b0;
    tick();
    if_req = 1; if_addr = 32'h10;
    #1;
    chk("f1_gnt", {30'h0, if_gnt, d_gnt}, 2'b10);
    tick();
    if_req = 0;
    chk("f1_req", {31'h0, mem_req}, 1);
    chk("f1_addr", mem_addr, 32'h10);
    chk("f1_we", {31'h0, mem_we}, 0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("f1_req_drop", {31'h0, mem_req}, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    tick();
    mem_rvalid = 0;
    chk("f1_rvalid", {29'h0, if_rvalid, d_rvalid, bus_err}, 3'b100);
    chk("f1_rdata", if_rdata, 32'h0050_0093);
    tick();
    chk("f1_pulse", {31'h0, if_rvalid}, 0);
    if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h100;
    #1;
    chk("prio_gnt", {30'h0, if_gnt, d_gnt}, 2'b01);
    tick();
    d_req = 0;
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_busy_gnt", {31'h0, if_gnt}, 0);
    mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 0; mem_rvalid = 0;
    chk("ld_rvalid", {29'h0, if_rvalid, d_rvalid, bus_err}, 3'b010);
    chk("ld_rdata", d_rdata, 32'hCAFE_0001);
    chk("b2b_gnt", {30'h0, if_gnt, d_gnt}, 2'b10);
    tick();
    if_req = 0;
    chk("f2_addr", mem_addr, 32'h10);
    mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 0; mem_rvalid = 0;
    chk("f2_rvalid", {30'h0, if_rvalid, d_rvalid}, 2'b10);
    chk("f2_rdata", if_rdata, 32'h1234_5678);
    d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_gnt", {31'h0, d_gnt}, 1);
    tick();
    d_req = 0; d_we = 0;
    chk("st_we", {31'h0, mem_we}, 1);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_addr", mem_addr, 32'h104);
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 0;
    chk("st_req_drop", {31'h0, mem_req}, 0);
    chk("st_rvalid", {29'h0, if_rvalid, d_rvalid, bus_err}, 3'b010);
    chk("st_rdata", d_rdata, 0);
    d_req = 1; if_req = 1; d_addr = 32'h200; if_addr = 32'h80;
    for (int i = 0; i < 6; i++) begin
      logic exp_d;
      exp_d = (i != 4);
      #1;
      chk($sformatf("stv_gnt%0d", i), {30'h0, if_gnt, d_gnt}, {30'h0, !exp_d, exp_d});
      tick();
      chk($sformatf("stv_addr%0d", i), mem_addr, exp_d ? 32'h200 : 32'h80);
      mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5_0000 + i;
      tick();
      mem_ack = 0; mem_rvalid = 0;
      chk($sformatf("stv_rv%0d", i), {30'h0, if_rvalid, d_rvalid}, {30'h0, !exp_d, exp_d});
    end
    d_req = 0; if_req = 0;
    tick();
    if_req = 1; if_addr = 32'h20;
    tick();
    if_req = 0;
    repeat (15) tick();
    chk("tmo_req_held", {31'h0, mem_req}, 1);
    chk("tmo_no_rv", {31'h0, if_rvalid}, 0);
    tick();
    chk("tmo_req_drop", {31'h0, mem_req}, 0);
    chk("tmo_rvalid", {29'h0, if_rvalid, d_rvalid, bus_err}, 3'b101);
    chk("tmo_rdata", if_rdata, 0);
    tick();
    chk("tmo_err_clr", {30'h0, if_rvalid, bus_err}, 0);
    mem_rvalid = 1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 0; mem_ack = 0;
    tick();
    chk("stray_ignored", {29'h0, if_rvalid, d_rvalid, mem_req}, 0);
    if_req = 1; if_addr = 32'h30;
    tick();
    if_req = 0;
    mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
    reset = 1;
    #1;
    chk_idle_outs("rst_resp");
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    tick();
    reset = 0;
    tick();
    mem_rvalid = 0;
    tick();
    chk("rst_no_rv", {30'h0, if_rvalid, d_rvalid}, 0);
    chk("rst_rdata", if_rdata, 0);
    if_req = 1; if_addr = 32'h40;
    #1;
    chk("f3_gnt", {31'h0, if_gnt}, 1);
    tick();
    if_req = 0;
    chk("f3_addr", mem_addr, 32'h40);
    mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 0; mem_rvalid = 0;
    chk("f3_rvalid", {29'h0, if_rvalid, d_rvalid, bus_err}, 3'b100);
    chk("f3_rdata", if_rdata, 32'h0000_0013);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
